// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the BCM LED matrix driver.
// Holds the refresh sequencer state encoding and the bit-plane extraction used by the column shifter.
package led_matrix_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT,
      ST_LATCH_BLANK,
      ST_LATCH_PULSE
   } state_t;

   // Widest pixel word the extract helper accepts (16 bits per colour).
   localparam int MAX_PIX_W = 48;

   // Pull bit-plane p out of a packed {R,G,B} pixel with depth bits per colour.
   function automatic logic [2:0] plane_rgb(input logic [MAX_PIX_W-1:0] pix,
                                            input int depth, input int p);
      return {pix[2*depth+p], pix[depth+p], pix[p]};
   endfunction

endpackage

// File: rtl/led_column_shifter.sv
// Shifts one row/plane of pixel bits out to the panel.
// The RAM address is issued ahead of the data so that it lines up with each falling pix_clk.
module led_column_shifter
   import led_matrix_pkg::*;
#(
   parameter int COLS     = 64,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 3,
   parameter int CLK_DIV  = 2,
   parameter int ADDR_W   = 11,
   parameter int ROW_W    = 5,
   parameter int PL_W     = 2,
   localparam int PIX_W   = 3*DEPTH,
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [ROW_W-1:0]                  row,
   input  logic [PL_W-1:0]                   plane,
   output logic                              busy,
   output logic [ADDR_W-1:0]                 pix_addr,
   input  logic [CHANNELS-1:0][PIX_W-1:0]    pixel,
   output logic                              pix_clk,
   output logic [CHANNELS-1:0][2:0]          col_rgb
);

   logic [1:0]       lead;
   logic             run;
   logic [COL_W-1:0] col;
   logic [DIV_W-1:0] div;
   logic [PL_W-1:0]  pl;

   // lead counts down the two cycles between issuing column 0's address and its data arriving
   wire             first   = (lead == 2'd1);
   wire             div_end = (div == DIV_W'(CLK_DIV-1));
   wire             hi_end  = run && pix_clk && div_end;
   wire             lo_end  = run && !pix_clk && div_end;
   wire             last    = (col == COL_W'(COLS-1));
   wire             fall    = first || (hi_end && !last);
   wire [COL_W-1:0] cap_col = first ? '0 : col + 1'b1;

   assign busy = run || (lead != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_addr <= '0;
         lead     <= '0;
         run      <= 1'b0;
         col      <= '0;
         div      <= '0;
         pl       <= '0;
         pix_clk  <= 1'b0;
         col_rgb  <= '0;
      end else if (start && !busy) begin
         pix_addr <= ADDR_W'(int'(row) * COLS);
         lead     <= 2'd2;
         col      <= '0;
         div      <= '0;
         pl       <= plane;
      end else if (lead == 2'd2) begin
         lead <= 2'd1;
      end else if (fall) begin
         lead    <= '0;
         run     <= 1'b1;
         col     <= cap_col;
         div     <= '0;
         pix_clk <= 1'b0;
         for (int ch = 0; ch < CHANNELS; ch++)
            col_rgb[ch] <= plane_rgb(MAX_PIX_W'(pixel[ch]), DEPTH, int'(pl));
         // prefetch the next column; the last column leaves the address parked
         if (cap_col != COL_W'(COLS-1))
            pix_addr <= pix_addr + 1'b1;
      end else if (hi_end) begin
         pix_clk <= 1'b0;
         run     <= 1'b0;
         div     <= '0;
      end else if (lo_end) begin
         pix_clk <= 1'b1;
         div     <= '0;
      end else if (run) begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/led_matrix_bcm_driver.sv
// HUB75-style panel driver with binary-coded modulation over DEPTH bit-planes.
// The next plane is shifted in while the current one is on display; latch/blank sequencing lives here.
module led_matrix_bcm_driver
   import led_matrix_pkg::*;
#(
   parameter int COLS      = 64,
   parameter int ROW_PAIRS = 32,
   parameter int CHANNELS  = 2,
   parameter int DEPTH     = 3,
   parameter int CLK_DIV   = 2,
   parameter int BASE_ON   = 64,
   parameter int ADDR_W    = $clog2(COLS*ROW_PAIRS),
   localparam int ROW_W    = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1,
   localparam int PIX_W    = 3*DEPTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   output logic [ADDR_W-1:0]                 pix_addr,
   input  logic [CHANNELS-1:0][PIX_W-1:0]    pixel,
   output logic [ROW_W-1:0]                  row_sel,
   output logic                              pix_clk,
   output logic [CHANNELS-1:0][2:0]          col_rgb,
   output logic                              latch,
   output logic                              blank,
   output logic                              frame_done
);

   localparam int PL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TMR_W = $clog2((BASE_ON << (DEPTH-1)) + 1);

   state_t           st, st_nx;
   logic [ROW_W-1:0] row, nrow, st_row;
   logic [PL_W-1:0]  plane, nplane, st_plane;
   logic [TMR_W-1:0] timer;
   logic             start, busy;

   wire expired  = (timer == '0);
   wire row_last = (row == ROW_W'(ROW_PAIRS-1));
   wire pl_last  = (plane == PL_W'(DEPTH-1));

   led_column_shifter #(
      .COLS(COLS), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
      .ADDR_W(ADDR_W), .ROW_W(ROW_W), .PL_W(PL_W)
   ) u_shift (
      .clk(clk), .rst(rst), .start(start), .row(st_row), .plane(st_plane),
      .busy(busy), .pix_addr(pix_addr), .pixel(pixel), .pix_clk(pix_clk),
      .col_rgb(col_rgb)
   );

   always_comb begin
      nplane   = pl_last ? '0 : plane + 1'b1;
      nrow     = pl_last ? (row_last ? '0 : row + 1'b1) : row;
      st_nx    = st;
      start    = 1'b0;
      st_row   = row;
      st_plane = plane;
      case (st)
         ST_IDLE:        if (enable) begin
                            st_nx = ST_SHIFT;
                            start = 1'b1;
                         end
         ST_SHIFT:       if (!busy) st_nx = expired ? ST_LATCH_BLANK : ST_WAIT;
         ST_WAIT:        if (expired) st_nx = ST_LATCH_BLANK;
         ST_LATCH_BLANK: st_nx = ST_LATCH_PULSE;
         ST_LATCH_PULSE: if (enable) begin
                            // shifting of the following plane overlaps this plane's display
                            st_nx    = ST_SHIFT;
                            start    = 1'b1;
                            st_row   = nrow;
                            st_plane = nplane;
                         end else begin
                            st_nx = ST_IDLE;
                         end
         default:        st_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= ST_IDLE;
         row        <= '0;
         plane      <= '0;
         timer      <= '0;
         blank      <= 1'b1;
         latch      <= 1'b0;
         row_sel    <= '0;
         frame_done <= 1'b0;
      end else begin
         st         <= st_nx;
         latch      <= (st_nx == ST_LATCH_PULSE);
         frame_done <= (st_nx == ST_LATCH_PULSE) && row_last && pl_last;
         if (st_nx == ST_LATCH_PULSE)
            row_sel <= row;
         if (st == ST_LATCH_PULSE) begin
            row   <= enable ? nrow : '0;
            plane <= enable ? nplane : '0;
            timer <= TMR_W'(BASE_ON) << plane;
            blank <= 1'b0;
         end else if (!blank) begin
            // blank rises on the same edge the timer hits zero, so on-time is exactly the load value
            timer <= timer - 1'b1;
            if (timer == TMR_W'(1))
               blank <= 1'b1;
         end
      end
   end

endmodule

// File: doc/led_matrix_bcm_driver.md
Name: led_matrix_bcm_driver

Overview:
Parametrised successor to the fixed two-half, single-bit-per-colour LED panel driver. It drives a HUB75-style matrix with CHANNELS independent half-panels. Colour depth comes from binary-coded modulation (BCM) over DEPTH bit-planes. Shifting of the next plane overlaps display of the current one. It sits between the per-channel framebuffer RAMs (synchronous read, 1-cycle latency) and the panel connector.

Parameters:
COLS, 64, columns per row (pixel clocks per shift)
ROW_PAIRS, 32, row-select values; row_sel width ROW_W = $clog2(ROW_PAIRS)
CHANNELS, 2, independent half-panels / framebuffers
DEPTH, 3, bits per colour component; pixel width PIX_W = 3*DEPTH, packed {R,G,B}
CLK_DIV, 2, clk cycles per pix_clk half period (>=1)
BASE_ON, 64, clk cycles blank is low for plane 0; plane p uses BASE_ON<<p
ADDR_W, $clog2(COLS*ROW_PAIRS), framebuffer address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run refresh; sampled at plane boundaries
pix_addr  out  ADDR_W  framebuffer read address, shared by all channels
pixel  in  CHANNELS x PIX_W  read data per channel, valid 1 cycle after pix_addr
row_sel  out  ROW_W  panel row decoder
pix_clk  out  1  panel shift clock
col_rgb  out  CHANNELS x 3  {R,G,B} bit of the current plane per channel
latch  out  1  panel latch strobe
blank  out  1  panel output disable (1 = dark)
frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset values: pix_addr=0, row_sel=0, pix_clk=0, col_rgb=0, latch=0, blank=1, frame_done=0. State is IDLE, shift cursor is (row 0, plane 0), display timer is expired. Reset mid-operation gives these values on the next cycle.
- Scan order: for row r = 0..ROW_PAIRS-1, plane p = 0..DEPTH-1; wraps to (0,0).
- pix_addr = r*COLS + c for column c = 0..COLS-1.
- col_rgb[ch] = {pixel[ch][2*DEPTH+p], pixel[ch][DEPTH+p], pixel[ch][p]}.
- Shifter states: IDLE -> SHIFT -> WAIT -> LATCH -> SHIFT / IDLE.
  - IDLE: leave when enable=1.
  - SHIFT: per column, col_rgb is updated on the cycle pix_clk falls. pix_clk stays low CLK_DIV cycles, then high CLK_DIV cycles. The address for column c is issued one cycle before its data is needed. After column COLS-1's high phase, pix_clk=0 and col_rgb holds; go to WAIT.
  - WAIT: stay until the display timer is expired.
  - LATCH is 2 cycles:
    - Cycle 1: blank=1.
    - Cycle 2: latch=1, row_sel = row of the just-shifted data, blank stays 1.
    - Next cycle: latch=0, blank=0, and the display timer loads BASE_ON<<p of the latched plane.
    - Exit: if enable=1, the cursor advances and SHIFT starts the same cycle; if enable=0, go to IDLE with blank=1, cursor reset to (0,0), and the timer allowed to expire.
- Display timer: decrements each cycle while blank=0. blank returns to 1 when it reaches 0, which marks it expired. blank is therefore low exactly BASE_ON<<p cycles per plane.
- frame_done: 1 on the LATCH cycle 2 that latches (ROW_PAIRS-1, DEPTH-1).
- Simultaneous events: shift completing on the same cycle the timer expires goes WAIT -> LATCH with no extra cycle. enable dropping mid-SHIFT is ignored until the LATCH exit.
- Arithmetic: the timer is wide enough for BASE_ON<<(DEPTH-1); no wrap. Address and column counters wrap only through the scan-order rules.

Decomposition:
- Package led_matrix_pkg: shifter state enum and a plane-bit extract function (pixel, p) -> 3-bit RGB.
- Sub-module led_column_shifter: column counter, pix_addr, RAM-latency alignment, pix_clk divider, col_rgb. Handshake is start/busy.
- Top module: scan cursor, display timer, latch/blank sequencing, frame_done.

Test Plan:
(Bench config: COLS=4, ROW_PAIRS=2, CHANNELS=2, DEPTH=2, CLK_DIV=1, BASE_ON=8; RAM models return pixel[ch] = addr ^ ch after 1 cycle.)
- Reset then enable=1: pix_addr sequence 0,1,2,3, four pix_clk rising edges each 2 cycles apart. Ch0 col_rgb for plane 0 equals bits {4,2,0} of addr 0..3. latch pulses once, then row_sel=0.
- Plane timing: blank low exactly 8 cycles after plane-0 latch and exactly 16 cycles after plane-1 latch. blank=1 during every latch pulse.
- Overlap: the second plane's pix_clk edges occur while blank=0. Its latch occurs on the 2nd cycle after the timer expires.
- Frame: after 4 latches, frame_done is one 1-cycle pulse, coincident with latch for (row 1, plane 1). The next pix_addr is 0.
- enable=0 mid-SHIFT: the current shift and latch complete, then IDLE with blank=1. Re-enable restarts at pix_addr=0, plane 0.
- rst=1 mid-DISPLAY: the next cycle shows all outputs at reset values. After release plus enable, the sequence matches the first test.
